// File: rtl/multicycle_control.sv
// multicycle_control
//   Control FSM for a small multicycle datapath. It fetches instructions
//   while Run is high, executes R-type (opcode 0x00) instructions in
//   FETCH -> DECODE -> EXEC -> WB, parks in HALT on opcode 0x3F and flags any
//   other opcode as illegal. It also counts retired R-type instructions
//   with a saturating counter.
//
// Ports
//   CLK, RESET    clock; synchronous active-low reset
//   Run           level enable for starting / continuing instruction fetch
//   MemReady      instruction memory data valid
//   Opcode        INSTRUCTION[31:26] from the instruction register
//   MemRead       instruction fetch request
//   IRWrite       instruction register load enable
//   PCWrite       PC <= PC+4 enable
//   RegWrite      register file write enable
//   ALUOp         00 = add, 10 = use funct field
//   Busy          high outside IDLE and HALT
//   Halted        high in HALT
//   IllegalOp     single-cycle pulse on an unsupported opcode in DECODE
//   InstrCount    saturating count of retired R-type instructions
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Run,
    input  logic             MemReady,
    input  logic [5:0]       Opcode,
    output logic             MemRead,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUOp,
    output logic             Busy,
    output logic             Halted,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0]       OP_RTYPE = 6'h00;
    localparam logic [5:0]       OP_HALT  = 6'h3F;
    localparam logic [1:0]       ALU_ADD  = 2'b00;
    localparam logic [1:0]       ALU_FN   = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    // Next-state and retired-instruction counter.
    always_comb begin
        state_d       = state_q;
        instr_count_d = instr_count_q;
        case (state_q)
            S_IDLE:   if (Run) state_d = S_FETCH;
            // No timeout: a stalled memory simply holds the FSM here.
            S_FETCH:  if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                if (Opcode == OP_RTYPE)     state_d = S_EXEC;
                else if (Opcode == OP_HALT) state_d = S_HALT;
                else                        state_d = Run ? S_FETCH : S_IDLE;
            end
            S_EXEC:   state_d = S_WB;
            S_WB: begin
                // Saturate rather than wrap.
                if (instr_count_q != '1) instr_count_d = instr_count_q + CNT_ONE;
                state_d = Run ? S_FETCH : S_IDLE;
            end
            // Only reset leaves HALT.
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore output decode. Everything is qualified with RESET so that no
    // write strobe can fire while reset is being applied, even before the
    // first reset edge has put the state register into a known value.
    always_comb begin
        MemRead   = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUOp     = ALU_ADD;
        Busy      = 1'b0;
        Halted    = 1'b0;
        IllegalOp = 1'b0;
        if (RESET) begin
            Busy   = (state_q != S_IDLE) && (state_q != S_HALT);
            Halted = (state_q == S_HALT);
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE: IllegalOp = (Opcode != OP_RTYPE) && (Opcode != OP_HALT);
                S_EXEC:   ALUOp = ALU_FN;
                S_WB: begin
                    ALUOp    = ALU_FN;
                    RegWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q       <= S_IDLE;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign InstrCount = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       Run = 1'b0;
    logic       MemReady = 1'b1;
    logic [5:0] Opcode = 6'h00;

    logic        a_MemRead, a_IRWrite, a_PCWrite, a_RegWrite, a_Busy, a_Halted, a_IllegalOp;
    logic [1:0]  a_ALUOp;
    logic [15:0] a_InstrCount;
    logic        b_MemRead, b_IRWrite, b_PCWrite, b_RegWrite, b_Busy, b_Halted, b_IllegalOp;
    logic [1:0]  b_ALUOp;
    logic [3:0]  b_InstrCount;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    multicycle_control #(.CNT_W(16)) dut16 (
        .CLK(CLK), .RESET(RESET), .Run(Run), .MemReady(MemReady), .Opcode(Opcode),
        .MemRead(a_MemRead), .IRWrite(a_IRWrite), .PCWrite(a_PCWrite), .RegWrite(a_RegWrite),
        .ALUOp(a_ALUOp), .Busy(a_Busy), .Halted(a_Halted), .IllegalOp(a_IllegalOp),
        .InstrCount(a_InstrCount)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .Run(Run), .MemReady(MemReady), .Opcode(Opcode),
        .MemRead(b_MemRead), .IRWrite(b_IRWrite), .PCWrite(b_PCWrite), .RegWrite(b_RegWrite),
        .ALUOp(b_ALUOp), .Busy(b_Busy), .Halted(b_Halted), .IllegalOp(b_IllegalOp),
        .InstrCount(b_InstrCount)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: where the controller is in an instruction's life
    // (0 idle, 1 fetching, 2 decoding, 3 executing, 4 writing back, 5 halted)
    // and how many R-type instructions have retired (unbounded).
    int m_stage = 0;
    int m_cnt   = 0;
    bit known   = 0;

    always @(posedge CLK) begin
        if (!RESET) begin
            m_stage <= 0;
            m_cnt   <= 0;
            known   <= 1'b1;
        end else if (known) begin
            if (m_stage == 0 && Run) m_stage <= 1;
            if (m_stage == 1 && MemReady) m_stage <= 2;
            if (m_stage == 2) begin
                if (Opcode == 6'h00)      m_stage <= 3;
                else if (Opcode == 6'h3F) m_stage <= 5;
                else                      m_stage <= Run ? 1 : 0;
            end
            if (m_stage == 3) m_stage <= 4;
            if (m_stage == 4) begin
                m_cnt   <= m_cnt + 1;
                m_stage <= Run ? 1 : 0;
            end
        end
    end

    int e_mr, e_irw, e_pcw, e_rw, e_alu, e_busy, e_halt, e_ill, e_c16, e_c4;

    always @(negedge CLK) begin
        if (known) begin
            e_mr   = (RESET && m_stage == 1) ? 1 : 0;
            e_irw  = (e_mr == 1 && MemReady) ? 1 : 0;
            e_pcw  = e_irw;
            e_rw   = (RESET && m_stage == 4) ? 1 : 0;
            e_alu  = (RESET && (m_stage == 3 || m_stage == 4)) ? 2 : 0;
            e_busy = (RESET && m_stage >= 1 && m_stage <= 4) ? 1 : 0;
            e_halt = (RESET && m_stage == 5) ? 1 : 0;
            e_ill  = (RESET && m_stage == 2 && Opcode != 6'h00 && Opcode != 6'h3F) ? 1 : 0;
            e_c16  = (m_cnt > 65535) ? 65535 : m_cnt;
            e_c4   = (m_cnt > 15) ? 15 : m_cnt;
            chk("MemRead",    a_MemRead,    e_mr);
            chk("IRWrite",    a_IRWrite,    e_irw);
            chk("PCWrite",    a_PCWrite,    e_pcw);
            chk("RegWrite",   a_RegWrite,   e_rw);
            chk("ALUOp",      a_ALUOp,      e_alu);
            chk("Busy",       a_Busy,       e_busy);
            chk("Halted",     a_Halted,     e_halt);
            chk("IllegalOp",  a_IllegalOp,  e_ill);
            chk("InstrCount", a_InstrCount, e_c16);
            chk("w4 MemRead",    b_MemRead,    e_mr);
            chk("w4 PCWrite",    b_PCWrite,    e_pcw);
            chk("w4 RegWrite",   b_RegWrite,   e_rw);
            chk("w4 Halted",     b_Halted,     e_halt);
            chk("w4 IllegalOp",  b_IllegalOp,  e_ill);
            chk("w4 InstrCount", b_InstrCount, e_c4);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset for two edges, then look at outputs while reset is still held.
        step();
        step();
        @(negedge CLK);
        chk("rst Busy", a_Busy, 0);
        chk("rst MemRead", a_MemRead, 0);
        chk("rst InstrCount", a_InstrCount, 0);
        step();
        RESET = 1'b1;

        // Three back-to-back R-type instructions; cycle 0 is the IDLE cycle
        // in which Run is first seen.
        Run = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            @(negedge CLK);
            chk("pcw cycle", a_PCWrite, (k == 1 || k == 5 || k == 9) ? 1 : 0);
            chk("regw cycle", a_RegWrite, (k == 4 || k == 8 || k == 12) ? 1 : 0);
            step();
            if (k == 11) Run = 1'b0;
        end
        @(negedge CLK);
        chk("count after 3", a_InstrCount, 3);
        chk("idle after 3", a_Busy, 0);

        // Memory stall: three FETCH cycles without data, Run dropped mid-flight.
        step();
        Run = 1'b1;
        MemReady = 1'b0;
        step();
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            chk("stall MemRead", a_MemRead, 1);
            chk("stall IRWrite", a_IRWrite, 0);
            step();
        end
        MemReady = 1'b1;
        Run = 1'b0;
        begin
            int n;
            n = 4;
            @(negedge CLK);
            while (a_RegWrite !== 1'b1 && n < 30) begin
                @(negedge CLK);
                n++;
            end
            chk("stall latency", n, 7);
        end
        step();
        @(negedge CLK);
        chk("count after stall", a_InstrCount, 4);
        chk("idle after stall", a_Busy, 0);

        // Illegal opcode, then a legal one with Run low.
        step();
        Opcode = 6'h08;
        Run = 1'b1;
        step();
        step();
        @(negedge CLK);
        chk("illegal pulse", a_IllegalOp, 1);
        step();
        Opcode = 6'h00;
        Run = 1'b0;
        @(negedge CLK);
        chk("illegal single", a_IllegalOp, 0);
        chk("refetch after illegal", a_MemRead, 1);
        chk("count after illegal", a_InstrCount, 4);
        repeat (4) step();
        @(negedge CLK);
        chk("count after refetch", a_InstrCount, 5);

        // Run dropped during EXEC: WB still happens, then IDLE.
        step();
        Run = 1'b1;
        repeat (3) step();
        Run = 1'b0;
        step();
        @(negedge CLK);
        chk("wb after run drop", a_RegWrite, 1);
        step();
        @(negedge CLK);
        chk("idle after run drop", a_Busy, 0);
        chk("count after run drop", a_InstrCount, 6);

        // Halt opcode: stays halted with Run high until reset.
        step();
        Run = 1'b1;
        Opcode = 6'h3F;
        repeat (3) step();
        repeat (20) begin
            @(negedge CLK);
            chk("halt held", a_Halted, 1);
            chk("halt not busy", a_Busy, 0);
            step();
        end
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        Run = 1'b0;
        Opcode = 6'h00;
        @(negedge CLK);
        chk("unhalt", a_Halted, 0);
        chk("unhalt count", a_InstrCount, 0);

        // Reset during EXEC, WB and FETCH: no write strobes, count stays 0.
        step();
        Run = 1'b1;
        repeat (3) step();
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst exec ALUOp", a_ALUOp, 0);
        step();
        RESET = 1'b1;
        Run = 1'b0;
        @(negedge CLK);
        chk("rst exec idle", a_Busy, 0);
        chk("rst exec RegWrite", a_RegWrite, 0);
        step();
        Run = 1'b1;
        repeat (4) step();
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst wb RegWrite", a_RegWrite, 0);
        step();
        RESET = 1'b1;
        Run = 1'b1;
        step();
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst fetch PCWrite", a_PCWrite, 0);
        chk("rst wb count", a_InstrCount, 0);
        step();
        RESET = 1'b1;
        Run = 1'b0;
        step();

        // 17 R-type instructions: the 4-bit counter saturates at 15.
        Run = 1'b1;
        repeat (68) step();
        Run = 1'b0;
        step();
        @(negedge CLK);
        chk("sat w4", b_InstrCount, 15);
        chk("count w16", a_InstrCount, 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset; sampled on rising CLK edge.
REQ-004 Run  input  1  level; 1 = controller may start or continue fetching instructions.
REQ-005 MemReady  input  1  instruction memory data valid this cycle.
REQ-006 Opcode  input  6  INSTRUCTION[31:26] from the instruction register.
REQ-007 MemRead  output  1  request instruction fetch.
REQ-008 IRWrite  output  1  instruction register load enable.
REQ-009 PCWrite  output  1  PC load enable (PC <= PC+4).
REQ-010 RegWrite  output  1  register file write enable.
REQ-011 ALUOp  output  2  to ALU control: 00 add, 10 use funct.
REQ-012 Busy  output  1  1 in any state other than IDLE and HALT.
REQ-013 Halted  output  1  1 in HALT.
REQ-014 IllegalOp  output  1  one-cycle pulse on an unsupported opcode.
REQ-015 InstrCount  output  CNT_W  count of retired R-type instructions.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, WB, HALT; every output except InstrCount SHALL be a Moore decode of the state register, plus MemReady where listed below.
REQ-017 IDLE: all strobes 0; go to FETCH when Run=1, else stay.
REQ-018 FETCH: MemRead=1; when MemReady=1, IRWrite=1 and PCWrite=1 in that same cycle, then go to DECODE; when MemReady=0, stay with IRWrite=PCWrite=0, with no timeout.
REQ-019 DECODE (one cycle): if Opcode=6'h00, go to EXEC; if Opcode=6'h3F, go to HALT; otherwise assert IllegalOp=1 for this cycle and go to FETCH if Run=1, else IDLE.
REQ-020 EXEC (one cycle): ALUOp=2'b10, then go to WB.
REQ-021 WB (one cycle): ALUOp=2'b10, RegWrite=1, InstrCount increments by 1; then go to FETCH if Run=1, else IDLE.
REQ-022 ALUOp SHALL be 2'b00 in every state except EXEC and WB.
REQ-023 HALT: Halted=1, all strobes 0; leave only by reset, ignoring Run.
REQ-024 An R-type instruction SHALL take exactly 4 cycles (FETCH through WB) when MemReady=1 on the first FETCH cycle; each MemReady=0 cycle adds 1 cycle.
REQ-025 Run deasserted mid-instruction SHALL NOT abort it; the instruction completes, then the FSM goes to IDLE.
REQ-026 InstrCount SHALL saturate at all-ones and never wrap; illegal opcodes and the halt opcode SHALL NOT count.
REQ-027 RegWrite, PCWrite and IRWrite SHALL never be 1 in the same cycle as RESET=0.

Reset
REQ-028 When RESET=0 at a rising edge, state SHALL become IDLE and InstrCount SHALL become 0, from any state including HALT and mid-instruction.
REQ-029 During and immediately after reset: MemRead=IRWrite=PCWrite=RegWrite=0, ALUOp=00, Busy=0, Halted=0, IllegalOp=0.

Verification
REQ-030 Reset, then Run=1, MemReady=1, Opcode=0 for 3 instructions -> states F,D,E,W repeat; PCWrite pulses at cycles 1, 5, 9 after Run; RegWrite at 4, 8, 12; InstrCount=3.
REQ-031 MemReady=0 for 3 cycles in FETCH -> MemRead held 1, no IRWrite/PCWrite, DECODE entered on the 4th cycle, instruction latency 7.
REQ-032 Opcode=6'h08 in DECODE -> IllegalOp=1 for exactly 1 cycle, no EXEC/WB, InstrCount unchanged, next state FETCH.
REQ-033 Opcode=6'h3F -> Halted=1, Busy=0, stays halted for 20 cycles with Run=1; RESET=0 -> IDLE, InstrCount=0.
REQ-034 Run dropped during EXEC -> WB completes with RegWrite=1 and InstrCount+1, then IDLE; RESET=0 asserted during EXEC -> next cycle IDLE, no RegWrite.
REQ-035 CNT_W=4, 17 R-type instructions -> InstrCount holds at 15.
